// File: rtl/ariane_pkg.sv
// Shared FP format constants and operand-control enums.
// Used by the fixed-to-float converter pipeline.
package ariane_pkg;

    localparam int FP32_EXP_W = 8;
    localparam int FP32_MAN_W = 23;
    localparam int FP32_BIAS  = 127;

    localparam int FP64_EXP_W = 11;
    localparam int FP64_MAN_W = 52;
    localparam int FP64_BIAS  = 1023;

    typedef enum logic {
        FMT_FP32 = 1'b0,
        FMT_FP64 = 1'b1
    } fmt_e;

    typedef enum logic {
        RM_RNE = 1'b0,
        RM_RTZ = 1'b1
    } rm_e;

endpackage

// File: rtl/lzc_fix.sv
// Leading-zero counter, binary-halving tree, purely combinational.
// Ports: in_i operand, cnt_o leading zeros, zero_o operand is all zeros.
module lzc_fix #(
    parameter int WIDTH = 64
) (
    input  logic [WIDTH-1:0]         in_i,
    output logic [$clog2(WIDTH)-1:0] cnt_o,
    output logic                     zero_o
);

    localparam int L = $clog2(WIDTH);
    localparam int N = 1 << L;

    // Left-align into a power-of-two window; trailing pad keeps the count.
    logic [N-1:0] pad;
    assign pad = N'(in_i) << (N - WIDTH);

    // Each level keeps the half that holds the leading one.
    for (genvar i = 0; i < L; i++) begin : g_lvl
        localparam int W = N >> i;
        logic [W-1:0] v;
        logic         hit;
        if (i == 0) begin : g_root
            assign v = pad;
        end else begin : g_node
            assign v = g_lvl[i-1].hit ? g_lvl[i-1].v[W-1:0]
                                      : g_lvl[i-1].v[2*W-1:W];
        end
        assign hit = ~|v[W-1:W/2];
        assign cnt_o[L-1-i] = hit;
    end

    // The final pair is all zero only when the whole operand was zero.
    assign zero_o = ~|g_lvl[L-1].v;

endmodule

// File: rtl/fix2float_pipe.sv
// Signed fixed-point to FP32/FP64 converter, 3 stages with backpressure.
// Ports: clk_i, rst_ni; in_valid_i/in_ready_o with fix_i, fmt_i, rm_i;
//        out_valid_o/out_ready_i with float_o (FP32 NaN-boxed) and nx_o.
module fix2float_pipe
    import ariane_pkg::*;
#(
    parameter int FIX_W  = 64,
    parameter int FRAC_W = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [FIX_W-1:0] fix_i,
    input  logic             fmt_i,
    input  logic             rm_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [63:0]      float_o,
    output logic             nx_o
);

    localparam int LZ_W  = $clog2(FIX_W);
    localparam int EXP_W = FP64_EXP_W;
    localparam int PAD   = FP64_MAN_W + 1;
    localparam int EXT_W = FIX_W - 1 + PAD;

    logic adv;
    assign adv        = ~(out_valid_o & ~out_ready_i);
    assign in_ready_o = adv;

    // S1: sign and magnitude
    logic             in_sign;
    logic [FIX_W-1:0] in_mag;
    assign in_sign = fix_i[FIX_W-1];
    assign in_mag  = in_sign ? (~fix_i + FIX_W'(1)) : fix_i;

    logic             s1_valid;
    logic             s1_sign;
    logic [FIX_W-1:0] s1_mag;
    fmt_e             s1_fmt;
    rm_e              s1_rm;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_valid <= 1'b0;
            s1_sign  <= 1'b0;
            s1_mag   <= '0;
            s1_fmt   <= FMT_FP32;
            s1_rm    <= RM_RNE;
        end else if (adv) begin
            s1_valid <= in_valid_i;
            if (in_valid_i) begin
                s1_sign <= in_sign;
                s1_mag  <= in_mag;
                s1_fmt  <= fmt_e'(fmt_i);
                s1_rm   <= rm_e'(rm_i);
            end
        end
    end

    // S2: leading-one detect and left-normalise
    logic [LZ_W-1:0]  lz;
    logic             mag_zero;
    logic [FIX_W-2:0] frac_c;
    logic [EXP_W-1:0] bias_c;
    logic [EXP_W-1:0] exp_c;

    lzc_fix #(
        .WIDTH (FIX_W)
    ) u_lzc (
        .in_i   (s1_mag),
        .cnt_o  (lz),
        .zero_o (mag_zero)
    );

    // The leading one shifts out of the top; only bits below it remain.
    assign frac_c = s1_mag[FIX_W-2:0] << lz;
    assign bias_c = (s1_fmt == FMT_FP64) ? EXP_W'(FP64_BIAS)
                                         : EXP_W'(FP32_BIAS);
    assign exp_c  = bias_c + EXP_W'(FIX_W - 1 - FRAC_W) - EXP_W'(lz);

    logic             s2_valid;
    logic             s2_sign;
    logic             s2_zero;
    logic [FIX_W-2:0] s2_frac;
    logic [EXP_W-1:0] s2_exp;
    fmt_e             s2_fmt;
    rm_e              s2_rm;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s2_valid <= 1'b0;
            s2_sign  <= 1'b0;
            s2_zero  <= 1'b1;
            s2_frac  <= '0;
            s2_exp   <= '0;
            s2_fmt   <= FMT_FP32;
            s2_rm    <= RM_RNE;
        end else if (adv) begin
            s2_valid <= s1_valid;
            s2_sign  <= s1_sign;
            s2_zero  <= mag_zero;
            s2_frac  <= frac_c;
            s2_exp   <= exp_c;
            s2_fmt   <= s1_fmt;
            s2_rm    <= s1_rm;
        end
    end

    // S3: round and pack
    logic [EXT_W-1:0]      ext;
    logic [FP64_MAN_W-1:0] man;
    logic                  grd;
    logic                  stk;
    logic                  inc;
    logic [FP64_MAN_W:0]   sum;
    logic                  carry;
    logic [EXP_W-1:0]      exp_r;
    logic [63:0]           pack_c;
    logic                  nx_c;

    always_comb begin
        // Zero padding supplies missing mantissa bits for narrow inputs.
        ext    = {s2_frac, {PAD{1'b0}}};
        man    = '0;
        grd    = 1'b0;
        stk    = 1'b0;
        if (s2_fmt == FMT_FP64) begin
            man = ext[EXT_W-1 -: FP64_MAN_W];
            grd = ext[EXT_W-1-FP64_MAN_W];
            stk = |ext[EXT_W-2-FP64_MAN_W:0];
        end else begin
            man = {{(FP64_MAN_W-FP32_MAN_W){1'b0}},
                   ext[EXT_W-1 -: FP32_MAN_W]};
            grd = ext[EXT_W-1-FP32_MAN_W];
            stk = |ext[EXT_W-2-FP32_MAN_W:0];
        end
        inc   = (s2_rm == RM_RNE) & grd & (stk | man[0]);
        sum   = {1'b0, man} + (FP64_MAN_W+1)'(inc);
        // An all-ones mantissa wraps to zero and bumps the exponent.
        carry = (s2_fmt == FMT_FP64) ? sum[FP64_MAN_W] : sum[FP32_MAN_W];
        exp_r = s2_exp + EXP_W'(carry);
        nx_c  = grd | stk;
        if (s2_fmt == FMT_FP64) begin
            pack_c = {s2_sign, exp_r, sum[FP64_MAN_W-1:0]};
        end else begin
            pack_c = {32'hFFFF_FFFF, s2_sign, exp_r[FP32_EXP_W-1:0],
                      sum[FP32_MAN_W-1:0]};
        end
        if (s2_zero) begin
            pack_c = (s2_fmt == FMT_FP64) ? 64'h0 : 64'hFFFF_FFFF_0000_0000;
            nx_c   = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            out_valid_o <= 1'b0;
            float_o     <= '0;
            nx_o        <= 1'b0;
        end else if (adv) begin
            out_valid_o <= s2_valid;
            float_o     <= pack_c;
            nx_o        <= nx_c;
        end
    end

endmodule

// File: tb/tb_fix2float_pipe.sv
// Directed bench for fix2float_pipe (FIX_W=64, FRAC_W=32).
// Vector table plus backpressure and mid-flight reset sequences.
module tb_fix2float_pipe;

    logic        clk_i;
    logic        rst_ni;
    logic        in_valid_i;
    logic        in_ready_o;
    logic [63:0] fix_i;
    logic        fmt_i;
    logic        rm_i;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [63:0] float_o;
    logic        nx_o;

    fix2float_pipe #(
        .FIX_W  (64),
        .FRAC_W (32)
    ) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .fix_i       (fix_i),
        .fmt_i       (fmt_i),
        .rm_i        (rm_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .float_o     (float_o),
        .nx_o        (nx_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [63:0] fix;
        logic        fmt;
        logic        rm;
        logic [63:0] flt;
        logic        nx;
        string       name;
    } vec_t;

    vec_t vq[$];
    int   errors = 0;
    int   checks = 0;

    task automatic check(input string name, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic add(input logic [63:0] fix, input logic fmt,
                       input logic rm, input logic [63:0] flt,
                       input logic nx, input string name);
        vec_t v;
        v.fix  = fix;
        v.fmt  = fmt;
        v.rm   = rm;
        v.flt  = flt;
        v.nx   = nx;
        v.name = name;
        vq.push_back(v);
    endtask

    // Issue one operand into an idle pipe, expect it after 3 edges.
    task automatic run_vec(input vec_t v);
        int got;
        @(posedge clk_i); #1;
        in_valid_i = 1'b1;
        fix_i      = v.fix;
        fmt_i      = v.fmt;
        rm_i       = v.rm;
        @(posedge clk_i); #1;
        in_valid_i = 1'b0;
        got = 0;
        for (int k = 1; k <= 6 && got == 0; k++) begin
            @(negedge clk_i);
            if (out_valid_o) got = k;
        end
        check({v.name, "_lat"}, 64'(got), 64'd3);
        if (got != 0) begin
            check({v.name, "_flt"}, float_o, v.flt);
            check({v.name, "_nx"}, 64'(nx_o), 64'(v.nx));
        end
    endtask

    logic [31:0] exp8 [8];
    int          sent;
    int          rcv;
    int          seen;

    initial begin
        rst_ni      = 1'b0;
        in_valid_i  = 1'b0;
        fix_i       = '0;
        fmt_i       = 1'b0;
        rm_i        = 1'b0;
        out_ready_i = 1'b1;

        repeat (2) @(negedge clk_i);
        check("rst_valid", 64'(out_valid_o), 64'd0);
        check("rst_float", float_o, 64'd0);
        check("rst_nx", 64'(nx_o), 64'd0);
        check("rst_ready", 64'(in_ready_o), 64'd1);
        rst_ni = 1'b1;

        add(64'h0000_0001_0000_0000, 0, 0, 64'hFFFFFFFF_3F800000, 0, "one32");
        add(64'h0000_0001_0000_0000, 1, 0, 64'h3FF0000000000000, 0, "one64");
        add(64'h8000_0000_0000_0000, 0, 0, 64'hFFFFFFFF_CF000000, 0, "minneg32");
        add(64'h8000_0000_0000_0000, 1, 0, 64'hC1E0000000000000, 0, "minneg64");
        add(64'h0000_0000_0000_0001, 0, 0, 64'hFFFFFFFF_2F800000, 0, "lsb32");
        add(64'h0, 0, 0, 64'hFFFFFFFF_00000000, 0, "zero32");
        add(64'h0, 1, 1, 64'h0, 0, "zero64");
        add(64'h0100_0003_0000_0000, 0, 0, 64'hFFFFFFFF_4B800002, 1, "rne_up");
        add(64'h0100_0003_0000_0000, 0, 1, 64'hFFFFFFFF_4B800001, 1, "rtz");
        add(64'h0100_0001_0000_0000, 0, 0, 64'hFFFFFFFF_4B800000, 1, "rne_tie");
        add(64'h7FFF_FFFF_8000_0000, 0, 0, 64'hFFFFFFFF_4F000000, 1, "carry");
        add(64'h7FFF_FFFF_8000_0000, 0, 1, 64'hFFFFFFFF_4EFFFFFF, 1, "carry_rtz");
        add(64'h7FFF_FFFF_8000_0000, 1, 0, 64'h41DFFFFFFFE00000, 0, "exact64");
        add(64'hFFFF_FFFF_0000_0000, 0, 0, 64'hFFFFFFFF_BF800000, 0, "neg1");
        add(64'hFFFF_FFFC_8000_0000, 1, 0, 64'hC00C000000000000, 0, "neg3p5");

        foreach (vq[i]) run_vec(vq[i]);

        // Backpressure: 8 operands, consumer stalls cycles 4..7.
        exp8[0] = 32'h3F800000; exp8[1] = 32'h40000000;
        exp8[2] = 32'h40400000; exp8[3] = 32'h40800000;
        exp8[4] = 32'h40A00000; exp8[5] = 32'h40C00000;
        exp8[6] = 32'h40E00000; exp8[7] = 32'h41000000;
        sent = 0;
        rcv  = 0;
        for (int cyc = 0; cyc < 24; cyc++) begin
            @(posedge clk_i); #1;
            out_ready_i = !(cyc >= 4 && cyc <= 7);
            if (sent < 8) begin
                in_valid_i = 1'b1;
                fix_i      = 64'(sent + 1) << 32;
                fmt_i      = 1'b0;
                rm_i       = 1'b0;
            end else begin
                in_valid_i = 1'b0;
            end
            @(negedge clk_i);
            check("bp_ready", 64'(in_ready_o),
                  64'(!(cyc >= 4 && cyc <= 7)));
            if (cyc >= 4 && cyc <= 7)
                check("bp_hold", float_o, {32'hFFFFFFFF, exp8[1]});
            if (in_valid_i && in_ready_o) sent++;
            if (out_valid_o && out_ready_i) begin
                if (rcv < 8)
                    check("bp_data", float_o, {32'hFFFFFFFF, exp8[rcv]});
                rcv++;
            end
        end
        in_valid_i  = 1'b0;
        out_ready_i = 1'b1;
        check("bp_count", 64'(rcv), 64'd8);

        // Reset with one result on the output and two operands behind it.
        @(posedge clk_i); #1;
        in_valid_i = 1'b1;
        fix_i      = 64'h0000_0005_0000_0000;
        @(posedge clk_i); #1;
        fix_i      = 64'h0000_0006_0000_0000;
        @(posedge clk_i); #1;
        fix_i      = 64'h0000_0007_0000_0000;
        @(posedge clk_i); #1;
        in_valid_i = 1'b0;
        check("rr_pre_valid", 64'(out_valid_o), 64'd1);
        check("rr_pre_float", float_o, 64'hFFFFFFFF_40A00000);
        #2;
        rst_ni = 1'b0;
        #1;
        check("rr_valid", 64'(out_valid_o), 64'd0);
        check("rr_float", float_o, 64'd0);
        check("rr_nx", 64'(nx_o), 64'd0);
        check("rr_ready", 64'(in_ready_o), 64'd1);
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b1;
        seen = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk_i);
            if (out_valid_o) seen++;
        end
        check("rr_stale", 64'(seen), 64'd0);
        check("rr_ready_after", 64'(in_ready_o), 64'd1);

        begin
            vec_t v;
            v.fix  = 64'h0000_0002_0000_0000;
            v.fmt  = 1'b1;
            v.rm   = 1'b0;
            v.flt  = 64'h4000000000000000;
            v.nx   = 1'b0;
            v.name = "rr_next";
            run_vec(v);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
